// File: rtl/adc_pkg.sv
// Shared types and constants for the flash ADC digital back end.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    OUT  = 2'd2
  } adc_state_e;

  localparam int THERM_BITS_DEF = 16;
  localparam int AVG_LOG2_DEF   = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/therm_bubble_encoder.sv
// Combinational bubble repair (3-input majority) and thermometer-to-binary encode.
module therm_bubble_encoder
  import adc_pkg::*;
#(
  parameter int  THERM_BITS = THERM_BITS_DEF,
  localparam int OUT_BITS   = clog2(THERM_BITS)
) (
  input  logic [THERM_BITS-1:0] t,
  output logic [OUT_BITS-1:0]   sample,
  output logic                  all_ones,
  output logic                  all_zeros,
  output logic                  err
);

  logic [THERM_BITS+1:0] tp;
  logic [THERM_BITS-1:0] c;
  logic [OUT_BITS:0]     ones;

  // Below the lowest comparator reads as 1, above the highest as 0.
  assign tp = {1'b0, t, 1'b1};

  for (genvar i = 0; i < THERM_BITS; i++) begin : g_maj
    assign c[i] = (tp[i] & tp[i+1]) | (tp[i] & tp[i+2]) | (tp[i+1] & tp[i+2]);
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < THERM_BITS; i++) ones = ones + (OUT_BITS+1)'(c[i]);
  end

  assign sample    = (ones == '0) ? '0 : OUT_BITS'(ones - (OUT_BITS+1)'(1));
  assign all_ones  = &c;
  assign all_zeros = ~|c;
  assign err       = (c != t);

endmodule

// File: rtl/flash_adc_encoder.sv
// Flash ADC back end: input synchroniser, encode register, burst averaging FSM.
module flash_adc_encoder
  import adc_pkg::*;
#(
  parameter int  THERM_BITS  = THERM_BITS_DEF,
  parameter int  AVG_LOG2    = AVG_LOG2_DEF,
  parameter int  SYNC_STAGES = 2,
  localparam int OUT_BITS    = clog2(THERM_BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cont,
  input  logic [THERM_BITS-1:0] therm_in,
  output logic [OUT_BITS-1:0]   code,
  output logic                  code_valid,
  output logic                  busy,
  output logic                  overrange,
  output logic                  underrange,
  output logic                  bubble_err
);

  localparam int ACC_W = OUT_BITS + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SYNC_STAGES-1:0][THERM_BITS-1:0] sync_q;
  logic [OUT_BITS-1:0] enc_sample, e_sample;
  logic enc_ones, enc_zeros, enc_err;
  logic e_ones, e_zeros, e_err;

  adc_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic ovr_acc, und_acc, err_acc;
  logic acc_clr, acc_en, out_load;

  // Free-running synchroniser; index 0 is the capture flop.
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], therm_in};

  therm_bubble_encoder #(.THERM_BITS(THERM_BITS)) u_enc (
    .t         (sync_q[SYNC_STAGES-1]),
    .sample    (enc_sample),
    .all_ones  (enc_ones),
    .all_zeros (enc_zeros),
    .err       (enc_err)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e_sample <= '0;
      e_ones   <= 1'b0;
      e_zeros  <= 1'b0;
      e_err    <= 1'b0;
    end else begin
      e_sample <= enc_sample;
      e_ones   <= enc_ones;
      e_zeros  <= enc_zeros;
      e_err    <= enc_err;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || cont) state_nxt = ACQ;
      ACQ:     if (cnt == CNT_LAST) state_nxt = OUT;
      OUT:     state_nxt = cont ? ACQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    out_load = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: acc_clr = start | cont;
      ACQ: begin
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      OUT: begin
        out_load = 1'b1;
        busy     = 1'b1;
        acc_clr  = cont;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      ovr_acc <= 1'b0;
      und_acc <= 1'b0;
      err_acc <= 1'b0;
    end else if (acc_clr) begin
      acc     <= '0;
      cnt     <= '0;
      ovr_acc <= 1'b0;
      und_acc <= 1'b0;
      err_acc <= 1'b0;
    end else if (acc_en) begin
      acc     <= acc + ACC_W'(e_sample);
      cnt     <= cnt + CNT_W'(1);
      ovr_acc <= ovr_acc | e_ones;
      und_acc <= und_acc | e_zeros;
      err_acc <= err_acc | e_err;
    end

  // Results hold between bursts; only the strobe is cleared every cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      code       <= '0;
      code_valid <= 1'b0;
      overrange  <= 1'b0;
      underrange <= 1'b0;
      bubble_err <= 1'b0;
    end else begin
      code_valid <= out_load;
      if (out_load) begin
        code       <= acc[ACC_W-1:AVG_LOG2];
        overrange  <= ovr_acc;
        underrange <= und_acc;
        bubble_err <= err_acc;
      end
    end

endmodule

// File: tb/tb_flash_adc_encoder.sv
// Randomised and directed check of flash_adc_encoder against a burst-level model.
module tb_flash_adc_encoder;

  localparam int N    = 16;
  localparam int A    = 2;
  localparam int S    = 2;
  localparam int NAVG = 1 << A;

  logic        clk = 1'b0;
  logic        reset, start, cont;
  logic [15:0] therm_in;
  logic [3:0]  code;
  logic        code_valid, busy, overrange, underrange, bubble_err;

  always #5 clk = ~clk;

  flash_adc_encoder #(.THERM_BITS(N), .AVG_LOG2(A), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cont       (cont),
    .therm_in   (therm_in),
    .code       (code),
    .code_valid (code_valid),
    .busy       (busy),
    .overrange  (overrange),
    .underrange (underrange),
    .bubble_err (bubble_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
  endtask

  // Sample value and flags of one comparator word, straight from the rules.
  function automatic void model_enc(input logic [15:0] w, output int s,
                                    output bit o, output bit z, output bit e);
    int ones;
    bit lo, hi, ci;
    ones = 0;
    e = 1'b0;
    for (int i = 0; i < N; i++) begin
      lo = (i == 0)     ? 1'b1 : w[i-1];
      hi = (i == N - 1) ? 1'b0 : w[i+1];
      ci = (int'(lo) + int'(w[i]) + int'(hi)) >= 2;
      ones += int'(ci);
      if (ci != w[i]) e = 1'b1;
    end
    s = (ones == 0) ? 0 : ones - 1;
    o = (ones == N);
    z = (ones == 0);
  endfunction

  // Model: a burst starting at edge b averages the words captured at edges
  // b-S .. b-S+NAVG-1 and reports after edge b+NAVG+1.
  logic [15:0] hist [0:8191];
  int cyc = 0;
  int burst_start = -1;
  int exp_code = 0;
  bit exp_valid = 0, exp_ovr = 0, exp_und = 0, exp_err = 0;
  int m_sum, m_s;
  bit m_o, m_z, m_e, f_o, f_z, f_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_start = -1;
      exp_valid = 0;
      exp_code = 0;
      exp_ovr = 0;
      exp_und = 0;
      exp_err = 0;
    end else begin
      if (cyc < 8191) cyc++;
      hist[cyc] = therm_in;
      exp_valid = 0;
      if (burst_start < 0) begin
        if (start || cont) burst_start = cyc;
      end else if (cyc == burst_start + NAVG + 1) begin
        m_sum = 0;
        f_o = 0; f_z = 0; f_e = 0;
        for (int j = 0; j < NAVG; j++) begin
          model_enc(hist[burst_start - S + j], m_s, m_o, m_z, m_e);
          m_sum += m_s;
          f_o |= m_o; f_z |= m_z; f_e |= m_e;
        end
        exp_code  = m_sum / NAVG;
        exp_ovr   = f_o;
        exp_und   = f_z;
        exp_err   = f_e;
        exp_valid = 1;
        burst_start = cont ? cyc : -1;
      end
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("code_valid", int'(code_valid), int'(exp_valid));
      chk("code", int'(code), exp_code);
      chk("busy", int'(busy), (burst_start >= 0) ? 1 : 0);
      chk("overrange", int'(overrange), int'(exp_ovr));
      chk("underrange", int'(underrange), int'(exp_und));
      chk("bubble_err", int'(bubble_err), int'(exp_err));
    end
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int n, k;
    n = $urandom_range(0, 16);
    w = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
    if ($urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, 15);
      w[k] = ~w[k];
    end
    if ($urandom_range(0, 15) == 0) w = 16'($urandom);
    return w;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_burst(input logic [15:0] w, input int want_code, input bit want_o,
                           input bit want_z, input bit want_e, input string tag);
    int lat;
    lat = -1;
    therm_in = w;
    idle_cycles(5);
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (code_valid && lat < 0) lat = i;
    end
    chk({tag, "_latency"}, lat, 6);
    chk({tag, "_code"}, int'(code), want_code);
    chk({tag, "_ovr"}, int'(overrange), int'(want_o));
    chk({tag, "_und"}, int'(underrange), int'(want_z));
    chk({tag, "_err"}, int'(bubble_err), int'(want_e));
  endtask

  initial begin
    int ps, last, nv, lat;
    bit po, pz, pe;

    reset = 1'b1; start = 1'b0; cont = 1'b0; therm_in = '0;

    // Pin the model encoder to hand-worked words.
    model_enc(16'h00FF, ps, po, pz, pe); chk("pin_00FF", ps, 7);
    model_enc(16'h00FB, ps, po, pz, pe); chk("pin_00FB", ps, 7); chk("pin_00FB_err", int'(pe), 1);
    model_enc(16'hFFFF, ps, po, pz, pe); chk("pin_FFFF", ps, 15); chk("pin_FFFF_o", int'(po), 1);
    model_enc(16'h0000, ps, po, pz, pe); chk("pin_0000", ps, 0); chk("pin_0000_z", int'(pz), 1);
    model_enc(16'h0005, ps, po, pz, pe); chk("pin_0005", ps, 1); chk("pin_0005_err", int'(pe), 1);

    #12;
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({overrange, underrange, bubble_err}), 0);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    idle_cycles(5);

    run_burst(16'h00FF, 7, 0, 0, 0, "clean");
    run_burst(16'h00FB, 7, 0, 0, 1, "bubble");
    run_burst(16'hFFFF, 15, 1, 0, 0, "over");
    run_burst(16'h0000, 0, 0, 1, 0, "under");

    // Averaging: E shows 4, 5, 6, 8 across the four ACQ cycles.
    therm_in = 16'h0000;
    idle_cycles(5);
    therm_in = 16'h001F; @(negedge clk);
    therm_in = 16'h003F; @(negedge clk);
    therm_in = 16'h007F; start = 1'b1; @(negedge clk);
    therm_in = 16'h01FF; start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (code_valid && lat < 0) lat = i;
    end
    chk("avg_seen", lat, 5);
    chk("avg_code", int'(code), 5);

    // Continuous mode, then drop cont mid-burst.
    therm_in = 16'h0FFF;
    idle_cycles(5);
    cont = 1'b1;
    last = -1; nv = 0;
    for (int i = 1; i <= 23; i++) begin
      @(negedge clk);
      if (code_valid) begin
        if (last >= 0) chk("cont_period", i - last, 5);
        last = i;
        nv++;
      end
    end
    chk("cont_count", nv, 4);
    chk("cont_code", int'(code), 11);
    cont = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (code_valid) nv++;
    end
    chk("cont_drop_count", nv, 1);
    chk("cont_drop_busy", int'(busy), 0);

    // Reset two cycles into a burst.
    therm_in = 16'h00FF;
    idle_cycles(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_code", int'(code), 0);
    chk("midrst_valid", int'(code_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_flags", int'({overrange, underrange, bubble_err}), 0);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (code_valid) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    run_burst(16'h00FF, 7, 0, 0, 0, "post_rst");

    // Random words, starts and continuous-mode toggles.
    for (int i = 0; i < 600; i++) begin
      therm_in = rand_word();
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      @(negedge clk);
    end
    start = 1'b0;
    cont = 1'b0;
    idle_cycles(12);
    chk("final_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_adc_encoder.md
# flash_adc_encoder

Parametrised digital back end for the on-chip flash ADC comparator bank. Resynchronises the asynchronous thermometer word from the comparators, repairs single-bit bubble errors, encodes it to binary, and averages a burst of 2^AVG_LOG2 samples into one result with a one-cycle valid strobe. It generalises the fixed 4-comparator thermometer encoder to any comparator count and adds averaging, range flags and a conversion state machine.

## Interface
- THERM_BITS, 16: comparator count N; must be ≥ 4 and a power of two.
- OUT_BITS, clog2(THERM_BITS): result width; derived, not overridden.
- AVG_LOG2, 2: samples per burst = 2^AVG_LOG2; 0 disables averaging.
- SYNC_STAGES, 2: synchroniser depth on the comparator inputs; ≥ 2.
- clk  in  1  single system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begins one burst; sampled in IDLE only.
- cont  in  1  continuous mode: bursts repeat back-to-back while high.
- therm_in  in  THERM_BITS  raw comparator outputs, asynchronous; bit 0 is the lowest threshold.
- code  out  OUT_BITS  averaged result.
- code_valid  out  1  one-cycle strobe: code and flags updated.
- busy  out  1  high in ACQ and OUT.
- overrange  out  1  at least one burst sample was all-ones.
- underrange  out  1  at least one burst sample was all-zeros.
- bubble_err  out  1  at least one burst sample needed correction.

## Operation
- Synchroniser: therm_in passes through SYNC_STAGES flops per bit, free-running and not gated by state.
- Bubble correction on the synchronised word t: c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1] = 1 and t[N] = 0.
- Sample error: a sample has an error when c ≠ t.
- Encoding: ones = popcount(c); sample = ones − 1, or 0 when ones = 0. Examples for N = 4: 0001→0, 0011→1, 0111→2, 1111→3, 0000→0.
- Encode register E: the sample value and its all-ones, all-zeros and error bits are registered every cycle, one pipeline stage after the synchroniser.
- FSM states: IDLE, ACQ, OUT.
  - IDLE → ACQ when start or cont is high. The accumulator, sample counter and sticky flag accumulators are cleared on this transition.
  - ACQ: each cycle, E.sample is added to the accumulator (width OUT_BITS + AVG_LOG2, cannot overflow) and the sticky flags are ORed in. After 2^AVG_LOG2 cycles → OUT.
  - OUT: code = accumulator >> AVG_LOG2 (truncating); flags are copied from the sticky accumulators; code_valid = 1. Then → ACQ (clearing the accumulators) if cont is high, else → IDLE.
- start outside IDLE is ignored. Dropping cont mid-burst completes the current burst, then returns to IDLE.
- code and the three flags hold until the next OUT.

## Timing
- Reset state: FSM in IDLE; code = 0; code_valid, busy, overrange, underrange and bubble_err all 0; accumulator, counter and synchroniser cleared.
- start high at edge 0 (while in IDLE): busy rises after edge 0. ACQ covers edges 1..2^AVG_LOG2. code_valid is high for the cycle after edge 2^AVG_LOG2 + 1.
- With AVG_LOG2 = 2: code_valid appears 5 cycles after start is sampled.
- Input-to-E latency: SYNC_STAGES + 1 cycles. A burst averages the E values present during its ACQ cycles.
- Continuous mode: one result every 2^AVG_LOG2 + 1 cycles; code_valid never stays high for two consecutive cycles.
- reset asserted mid-burst: all state and outputs return to reset values immediately. No code_valid is produced for the aborted burst.
- start and cont both high: identical to cont alone.

## Structure
- Package adc_pkg: FSM state enum (IDLE, ACQ, OUT), a clog2 function, and the default THERM_BITS / AVG_LOG2 constants.
- Sub-module therm_bubble_encoder: purely combinational, parameter THERM_BITS. Input t; outputs sample, all_ones, all_zeros, err. It is instantiated between the synchroniser and register E.
- Top level holds the synchroniser, register E, the FSM, the accumulator and the output registers.

## Test plan
- Clean levels, N = 16, AVG_LOG2 = 2: hold therm_in = 16'h00FF, pulse start → code = 7, code_valid on the 5th cycle after start is sampled, all flags 0.
- Bubble: hold 16'h00FB (bit 2 missing) → code = 7, bubble_err = 1, overrange = 0.
- Range: all-ones input → code = 15 and overrange = 1. All-zeros input → code = 0 and underrange = 1.
- Averaging: change therm_in every cycle so E presents 4, 5, 6, 8 during ACQ → code = 5 (sum 23 >> 2).
- Continuous mode: hold cont high with a constant input → code_valid every 5 cycles. Drop cont mid-burst → exactly one further code_valid, then busy = 0.
- Reset mid-burst: assert reset 2 cycles into ACQ → all outputs 0 immediately and no code_valid. A fresh start after release behaves as in the first scenario.
